// File: rtl/vga_sink_decoder.sv
// Receive-side VGA raster decoder: recovers hcnt/vcnt from sync pins, checks timing, tracks lock.
// Define VGA_SINK_STATS_EN to build the frame_count/err_count statistics counters.
module vga_sink_decoder #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned V_TOTAL     = 525,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        r,
  input  logic        g,
  input  logic        b,
  output logic [9:0]  px_x,
  output logic [9:0]  px_y,
  output logic        px_valid,
  output logic [2:0]  rgb_out,
  output logic        frame_start,
  output logic        locked,
  output logic        sync_err,
  output logic [15:0] frame_count,
  output logic [7:0]  err_count
);

  localparam logic [9:0] H_START = 10'(H_SYNC + H_BP);
  localparam logic [9:0] H_END   = 10'(H_SYNC + H_BP + H_ACTIVE - 1);
  localparam logic [9:0] V_START = 10'(V_SYNC + V_BP);
  localparam logic [9:0] V_END   = 10'(V_SYNC + V_BP + V_ACTIVE - 1);
  localparam logic [9:0] H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [2:0] LOCK_N  = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t      state, state_next;
  logic        hs1, vs1, hs2, vs2;
  logic [2:0]  rgb1;
  logic [9:0]  hcnt, vcnt, hcnt_next, vcnt_next;
  logic        vs_pending, pending_next;
  logic [2:0]  good, good_next, good_inc;
  logic        dirty, dirty_next;
  logic        hs_fall, vs_fall, restart, hunting;
  logic        line_bad, frame_bad, hs_lost, err, active;

  always_comb begin
    hs_fall      = hs2 & ~hs1;
    vs_fall      = vs2 & ~vs1;
    restart      = hs_fall & (vs_pending | vs_fall);
    pending_next = restart ? 1'b0 : (vs_pending | vs_fall);
    hcnt_next    = hs_fall ? '0 : ((hcnt == '1) ? hcnt : hcnt + 10'd1);
    if (restart)      vcnt_next = '0;
    else if (hs_fall) vcnt_next = (vcnt == '1) ? vcnt : vcnt + 10'd1;
    else              vcnt_next = vcnt;
    hunting   = (state != SEARCH);
    line_bad  = hunting & hs_fall & (hcnt != H_LAST);
    frame_bad = hunting & restart & (vcnt != V_LAST);
    hs_lost   = hunting & (hcnt_next == '1) & (hcnt != '1);
    err       = line_bad | frame_bad | hs_lost;
    active    = (hcnt_next >= H_START) && (hcnt_next <= H_END) &&
                (vcnt_next >= V_START) && (vcnt_next <= V_END);
  end

  // A frame that saw an error mid-way is not counted as good at its closing restart.
  always_comb begin
    state_next = state;
    good_next  = good;
    dirty_next = dirty;
    good_inc   = good + 3'd1;
    unique case (state)
      SEARCH: begin
        if (restart) begin
          state_next = ACQUIRE;
          good_next  = '0;
          dirty_next = 1'b0;
        end
      end
      ACQUIRE, LOCKED: begin
        if (hs_lost) begin
          state_next = SEARCH;
          good_next  = '0;
        end else if (line_bad || frame_bad) begin
          state_next = ACQUIRE;
          good_next  = '0;
          dirty_next = ~restart;
        end else if (restart) begin
          dirty_next = 1'b0;
          if (state == ACQUIRE && !dirty) begin
            good_next = good_inc;
            if (good_inc == LOCK_N) state_next = LOCKED;
          end
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SEARCH;
      hs1         <= 1'b0;
      vs1         <= 1'b0;
      hs2         <= 1'b0;
      vs2         <= 1'b0;
      rgb1        <= '0;
      hcnt        <= '0;
      vcnt        <= '0;
      vs_pending  <= 1'b0;
      good        <= '0;
      dirty       <= 1'b0;
      px_x        <= '0;
      px_y        <= '0;
      px_valid    <= 1'b0;
      rgb_out     <= '0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
    end else if (pix_en) begin
      hs1         <= hsync;
      vs1         <= vsync;
      rgb1        <= {r, g, b};
      hs2         <= hs1;
      vs2         <= vs1;
      hcnt        <= hcnt_next;
      vcnt        <= vcnt_next;
      vs_pending  <= pending_next;
      state       <= state_next;
      good        <= good_next;
      dirty       <= dirty_next;
      px_x        <= active ? hcnt_next - H_START : '0;
      px_y        <= active ? vcnt_next - V_START : '0;
      px_valid    <= active && (state_next == LOCKED);
      rgb_out     <= rgb1;
      frame_start <= restart;
      locked      <= (state_next == LOCKED);
      sync_err    <= err;
    end
  end

`ifdef VGA_SINK_STATS_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= '0;
      err_count   <= '0;
    end else if (pix_en) begin
      if (restart && state == LOCKED) frame_count <= frame_count + 16'd1;
      if (err && err_count != '1)     err_count   <= err_count + 8'd1;
    end
  end
`else
  assign frame_count = '0;
  assign err_count   = '0;
`endif

endmodule

// File: tb/tb_vga_sink_decoder.sv
// Scoreboard bench for vga_sink_decoder on a scaled-down raster (16x12 ticks, 8x8 active).
module tb_vga_sink_decoder;
  localparam int HA = 8, HS = 2, HB = 3, HT = 16;
  localparam int VA = 8, VS = 1, VB = 2, VT = 12;
`ifdef VGA_SINK_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clock = 1'b0, reset_n = 1'b1, pix_en = 1'b0;
  logic hsync = 1'b1, vsync = 1'b1, r = 1'b0, g = 1'b0, b = 1'b0;
  logic [9:0]  px_x, px_y;
  logic        px_valid, frame_start, locked, sync_err;
  logic [2:0]  rgb_out;
  logic [15:0] frame_count;
  logic [7:0]  err_count;

  vga_sink_decoder #(
    .H_ACTIVE(HA), .H_SYNC(HS), .H_BP(HB), .H_TOTAL(HT),
    .V_ACTIVE(VA), .V_SYNC(VS), .V_BP(VB), .V_TOTAL(VT), .LOCK_FRAMES(2)
  ) dut (
    .clock(clock), .reset_n(reset_n), .pix_en(pix_en),
    .hsync(hsync), .vsync(vsync), .r(r), .g(g), .b(b),
    .px_x(px_x), .px_y(px_y), .px_valid(px_valid), .rgb_out(rgb_out),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .frame_count(frame_count), .err_count(err_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  rgb;
    logic [31:0] tick;
  } pix_t;

  pix_t exp_q[$];
  int   fs_q[$];
  int   checks = 0, errors = 0;
  int   stim_tick = 0, mon_tick = 0, err_pulses = 0;
  logic tick_q = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, mon_tick);
    end
  endtask

  always @(posedge clock) tick_q <= pix_en;

  // Monitor: one observation per pixel tick, on the falling edge after it.
  always @(negedge clock) begin
    if (tick_q) begin
      pix_t e;
      mon_tick++;
      if (sync_err) err_pulses++;
      if (frame_start) begin
        if (fs_q.size() == 0) check("frame_start_unexpected", 32'(mon_tick), 32'd0);
        else check("frame_start_tick", 32'(mon_tick), 32'(fs_q.pop_front()));
      end
      if (px_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL px_valid_unexpected: got x=%0d y=%0d expected no pixel", px_x, px_y);
        end else begin
          e = exp_q.pop_front();
          check("px_tick", 32'(mon_tick), e.tick);
          check("px_x", 32'(px_x), 32'(e.x));
          check("px_y", 32'(px_y), 32'(e.y));
          check("rgb_out", 32'(rgb_out), 32'(e.rgb));
        end
      end
    end
  end

  function automatic logic [2:0] color(input int mode, input int x, input int y);
    if (mode == 1) return (x == 5 && y == 7) ? 3'b101 : 3'b000;
    return 3'(x + 2 * y);
  endfunction

  task automatic do_tick(input logic hs, input logic vs, input logic [2:0] c);
    @(negedge clock);
    hsync = hs;
    vsync = vs;
    {r, g, b} = c;
    pix_en = 1'b1;
    stim_tick++;
    @(negedge clock);
    pix_en = 1'b0;
  endtask

  task automatic pixel(input int h, input int v, input int mode, input bit expect_px);
    pix_t e;
    int   x = h - HS - HB;
    int   y = v - VS - VB;
    bit   act = (x >= 0) && (x < HA) && (y >= 0) && (y < VA);
    logic [2:0] c = act ? color(mode, x, y) : 3'b000;
    do_tick(h >= HS, v >= VS, c);
    if (act && expect_px) begin
      e.x = 10'(x);
      e.y = 10'(y);
      e.rgb = c;
      e.tick = 32'(stim_tick + 1);
      exp_q.push_back(e);
    end
    if (h == 0 && v == 0) fs_q.push_back(stim_tick + 1);
  endtask

  task automatic frame(input int mode, input bit expect_px, input int first_line,
                       input int last_line, input int long_line, input int first_h);
    for (int v = first_line; v <= last_line; v++) begin
      for (int h = (v == first_line) ? first_h : 0; h < HT + ((v == long_line) ? 1 : 0); h++)
        pixel(h, v, mode, expect_px);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px_valid"}, 32'(px_valid), 32'd0);
    check({tag, "_locked"}, 32'(locked), 32'd0);
    check({tag, "_px_xy"}, 32'({px_x, px_y}), 32'd0);
    check({tag, "_rgb_out"}, 32'(rgb_out), 32'd0);
    check({tag, "_pulses"}, 32'({frame_start, sync_err}), 32'd0);
    check({tag, "_stats"}, 32'({frame_count, err_count}), 32'd0);
  endtask

  initial begin
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_all_zero("reset");
    reset_n = 1'b1;

    // Lead-in line, then two frames to acquire; lock lands on the tick after frame 3 starts.
    frame(0, 0, VT - 1, VT - 1, -1, 0);
    frame(0, 0, 0, VT - 1, -1, 0);
    frame(0, 0, 0, VT - 1, -1, 0);
    check("locked_before_f3", 32'(locked), 32'd0);
    pixel(0, 0, 0, 1);
    check("locked_pre_edge", 32'(locked), 32'd0);
    pixel(1, 0, 0, 1);
    check("locked_rise", 32'(locked), 32'd1);
    check("frame_start_with_lock", 32'(frame_start), 32'd1);
    frame(0, 1, 0, VT - 1, -1, 2);
    check("no_err_ideal", 32'(err_pulses), 32'd0);

    frame(1, 1, 0, VT - 1, -1, 0);
    check("frame_count_f4", 32'(frame_count), STATS ? 32'd1 : 32'd0);

    // One over-long line while locked.
    frame(0, 0, 0, VT - 1, 1, 0);
    check("err_long_line", 32'(err_pulses), 32'd1);
    check("locked_after_long", 32'(locked), 32'd0);
    check("err_count_long", 32'(err_count), STATS ? 32'd1 : 32'd0);
    frame(0, 0, 0, VT - 1, -1, 0);
    check("locked_f6", 32'(locked), 32'd0);
    frame(0, 0, 0, VT - 1, -1, 0);
    check("locked_f7", 32'(locked), 32'd0);
    frame(0, 1, 0, VT - 1, -1, 0);
    check("relock_f8", 32'(locked), 32'd1);
    check("err_after_relock", 32'(err_pulses), 32'd1);

    // hsync stuck high: error fires when hcnt reaches 1023 (1009th idle tick).
    repeat (1000) do_tick(1'b1, 1'b1, 3'b000);
    check("no_err_before_sat", 32'(err_pulses), 32'd1);
    repeat (100) do_tick(1'b1, 1'b1, 3'b000);
    check("err_on_sat", 32'(err_pulses), 32'd2);
    check("locked_after_sat", 32'(locked), 32'd0);
    check("err_count_sat", 32'(err_count), STATS ? 32'd2 : 32'd0);

    frame(0, 0, 0, VT - 1, -1, 0);
    frame(0, 0, 0, VT - 1, -1, 0);
    check("locked_f11", 32'(locked), 32'd0);
    frame(0, 1, 0, VT - 1, -1, 0);
    check("relock_f12", 32'(locked), 32'd1);

    // Mid-frame reset while locked.
    frame(0, 1, 0, 5, -1, 0);
    check("locked_before_reset", 32'(locked), 32'd1);
    reset_n = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    frame(0, 0, 6, VT - 1, -1, 0);
    frame(0, 0, 0, VT - 1, -1, 0);
    frame(0, 0, 0, VT - 1, -1, 0);
    check("locked_f15", 32'(locked), 32'd0);
    frame(0, 1, 0, VT - 1, -1, 0);
    check("relock_f16", 32'(locked), 32'd1);
    check("err_total", 32'(err_pulses), 32'd2);
    check("err_count_after_reset", 32'(err_count), 32'd0);

    repeat (4) @(negedge clock);
    check("pixels_outstanding", 32'(exp_q.size()), 32'd0);
    check("frame_starts_outstanding", 32'(fs_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/vga_sink_decoder.md
# vga_sink_decoder

Receive-side counterpart of the game's VGA raster generator: consumes hsync, vsync and 1-bit r/g/b as driven onto the display pins, recovers the raster timing, and emits per-pixel coordinates with a valid flag. Sits on loopback/capture boards (and in the game testbench) to check generated frames pixel-by-pixel. Checks line and frame lengths against 640x480@60 timing and reports lock and errors.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_SYNC, 96, hsync low width in ticks
- H_BP, 48, back porch after hsync in ticks
- H_TOTAL, 800, ticks per line
- V_ACTIVE, 480, active lines per frame
- V_SYNC, 2, vsync low width in lines
- V_BP, 33, back porch lines after vsync
- V_TOTAL, 525, lines per frame
- LOCK_FRAMES, 2, consecutive good frames required for lock (1..7)

- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel tick enable (divided-clock strobe); all state advances only on ticks
- hsync  in  1  horizontal sync, active low
- vsync  in  1  vertical sync, active low
- r, g, b  in  1 each  pixel colour
- px_x  out  10  active-area column 0..H_ACTIVE-1
- px_y  out  10  active-area row 0..V_ACTIVE-1
- px_valid  out  1  rgb_out/px_x/px_y hold an active, locked pixel
- rgb_out  out  3  {r,g,b} of that pixel
- frame_start  out  1  one-tick pulse when line counter restarts
- locked  out  1  timing lock
- sync_err  out  1  one-tick pulse on any timing check failure
- frame_count  out  16  frames decoded while locked (see Configuration)
- err_count  out  8  sync_err pulses, saturating (see Configuration)

## Operation
- Stage 1: on each tick, register hsync, vsync, {r,g,b}. Stage 2: hold previous registered hsync/vsync for falling-edge detect.
- hcnt (10-bit): 0 on hsync-edge tick, else +1, saturates at 1023.
- vsync falling edge sets vs_pending; on next hsync edge (or same tick if coincident) vcnt <= 0 and vs_pending clears, frame_start pulses. Otherwise vcnt +1 per hsync edge, saturates at 1023.
- Active pixel: hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1] and vcnt in [V_SYNC+V_BP, V_SYNC+V_BP+V_ACTIVE-1]; px_x = hcnt-(H_SYNC+H_BP), px_y = vcnt-(V_SYNC+V_BP).
- Line check at each hsync edge (not the first after SEARCH): previous hcnt must equal H_TOTAL-1. Frame check at each vcnt restart (not the first): previous vcnt must equal V_TOTAL-1.
- FSM: SEARCH -> ACQUIRE on first vsync-driven vcnt restart. ACQUIRE: good-frame counter +1 per clean frame; reaching LOCK_FRAMES -> LOCKED. Any check failure in ACQUIRE/LOCKED: sync_err pulse, good count cleared, state ACQUIRE. hcnt reaching 1023 (no hsync): sync_err, state SEARCH.
- locked = (state == LOCKED). px_valid = active & locked.
- Simultaneous failure and lock-completion: failure wins.

## Timing
- Reset: all outputs 0, state SEARCH, counters 0; reset mid-frame discards lock, full re-acquire required.
- Pixel on pins at tick t appears on rgb_out with its px_x/px_y/px_valid after tick t+1 (two-tick latency); outputs hold between ticks.
- hsync falling edge sampled at tick t: that pixel has hcnt 0; pixel at t+H_SYNC+H_BP is px_x 0.
- locked rises on the frame_start tick completing the LOCK_FRAMES-th good frame; first px_valid in the following frame.
- frame_start, sync_err: exactly one tick (held across non-tick cycles).

## Configuration
- VGA_SINK_STATS_EN defined: frame_count increments (wrapping) on each frame_start while locked; err_count increments per sync_err, saturates at 255; both cleared only by reset.
- Undefined: frame_count and err_count tied to 0; no counter logic.

## Test plan
- Ideal 640x480 raster, pix_en every 2nd clock, 3 frames -> locked rises at end of frame 2 (LOCK_FRAMES=2), frame 3 yields exactly 307200 px_valid ticks, px_x 0..639, px_y 0..479.
- Pixel (x=5,y=7) driven 3'b101, others 0 -> rgb_out=3'b101 only with px_x=5, px_y=7, two ticks after pins.
- One line 801 ticks while locked -> single sync_err, locked drops, returns after 2 clean frames; err_count=1 with STATS.
- hsync held high 1100 ticks -> sync_err at hcnt 1023, state SEARCH, locked 0.
- reset_n pulsed low mid-frame while locked -> all outputs 0 immediately, re-lock after 2 full frames.
- vsync edge coincident with hsync edge -> frame_start same tick, vcnt 0, no sync_err.
